// File: rtl/stage1_pkg.sv
// Shared definitions for the stage-1 execute controller:
// opcodes, states, ALU selects and control-word layout.
package stage1_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ACK  = 4'd1,
        S_DEC  = 4'd2,
        S_MAR  = 4'd3,
        S_RD   = 4'd4,
        S_ALU  = 4'd5,
        S_WB   = 4'd6,
        S_ST   = 4'd7
    } state_t;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LDA = 5'b00001;
    localparam logic [4:0] OP_STA = 5'b00010;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_SHL = 5'b01100;
    localparam logic [4:0] OP_SHR = 5'b01101;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_NOT  = 3'd5,
        ALU_SHL  = 3'd6,
        ALU_SHR  = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic    is_mem;
        logic    is_sta;
        logic    is_unary;
        logic    is_nop;
        alu_op_t alu_op;
    } dec_t;

    // Control word bit positions; bits 15:11 are reserved and held low.
    localparam int CB_IR_LD  = 0;
    localparam int CB_DEC    = 1;
    localparam int CB_MAR_LD = 2;
    localparam int CB_MEM_RD = 3;
    localparam int CB_MDR_LD = 4;
    localparam int CB_RES_LD = 5;
    localparam int CB_ACC_LD = 6;
    localparam int CB_MEM_WR = 7;
    localparam int CB_ALU_LO = 8;
    localparam int CB_ALU_HI = 10;

    localparam logic [15:0] CP_IDLE = 16'h0000;
    localparam logic [15:0] CP_ACK  = 16'h0001;
    localparam logic [15:0] CP_DEC  = 16'h0002;
    localparam logic [15:0] CP_MAR  = 16'h0004;
    localparam logic [15:0] CP_RD   = 16'h0018;
    localparam logic [15:0] CP_ALU  = 16'h0020;
    localparam logic [15:0] CP_WB   = 16'h0040;
    localparam logic [15:0] CP_ST   = 16'h0080;

    function automatic logic [15:0] cp_with_alu(
        input logic [15:0] cp,
        input alu_op_t     op
    );
        return cp | {5'b0, op, 8'b0};
    endfunction

endpackage

// File: rtl/stage1_decode.sv
// Opcode class decoder for the stage-1 controller.
// Anything not executed here (branches, undefined) decodes as NOP.
module stage1_decode
    import stage1_pkg::*;
(
    input  logic [4:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_PASS;
        unique case (opcode)
            OP_LDA: dec.is_mem = 1'b1;
            OP_STA: dec.is_sta = 1'b1;
            OP_ADD: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_ADD;
            end
            OP_SUB: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_AND: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_AND;
            end
            OP_OR: begin
                dec.is_mem = 1'b1;
                dec.alu_op = ALU_OR;
            end
            OP_NOT: begin
                dec.is_unary = 1'b1;
                dec.alu_op   = ALU_NOT;
            end
            OP_SHL: begin
                dec.is_unary = 1'b1;
                dec.alu_op   = ALU_SHL;
            end
            OP_SHR: begin
                dec.is_unary = 1'b1;
                dec.alu_op   = ALU_SHR;
            end
            default: dec.is_nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage1.sv
// Stage-1 execute controller: accepts instructions from stage0,
// sequences fetch/ALU/write-back/store and owns CCR Z.
module stage1
    import stage1_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              stg0_state,
    input  logic [7:0]        instr,
    input  logic              alu_z,
    output logic              stg1_state,
    output logic              ccr_z,
    output logic              busy,
    output logic [CTRL_W-1:0] ctrl
);

    state_t      state;
    state_t      state_nx;
    logic        armed;
    logic [7:0]  ir1;
    dec_t        dec;
    logic        accept;
    logic        is_lda;
    logic [15:0] cw;
    logic        unused_flags;

    stage1_decode u_dec (
        .opcode (ir1[7:3]),
        .dec    (dec)
    );

    assign unused_flags = ^ir1[2:0];
    assign accept = (state == S_IDLE) && stg0_state && armed;
    assign is_lda = dec.is_mem && (dec.alu_op == ALU_PASS);

    // armed blocks re-accepting a request still held from the last ack
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            armed <= 1'b1;
            ir1   <= 8'h00;
            ccr_z <= 1'b0;
        end else begin
            state <= state_nx;
            if (!stg0_state)
                armed <= 1'b1;
            else if (accept)
                armed <= 1'b0;
            if (accept)
                ir1 <= instr;
            if (state == S_WB)
                ccr_z <= alu_z;
        end
    end

    always_comb begin
        state_nx = S_IDLE;
        unique case (state)
            S_IDLE: state_nx = accept ? S_ACK : S_IDLE;
            S_ACK:  state_nx = S_DEC;
            S_DEC: begin
                if (dec.is_mem || dec.is_sta)
                    state_nx = S_MAR;
                else if (dec.is_unary)
                    state_nx = S_ALU;
                else
                    state_nx = S_IDLE;
            end
            S_MAR:  state_nx = dec.is_sta ? S_ST : S_RD;
            S_RD:   state_nx = is_lda ? S_WB : S_ALU;
            S_ALU:  state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            S_ST:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // alu_op stays driven through WB so alu_z is valid when Z is captured
    always_comb begin
        cw = CP_IDLE;
        unique case (state)
            S_ACK:  cw = CP_ACK;
            S_DEC:  cw = CP_DEC;
            S_MAR:  cw = CP_MAR;
            S_RD:   cw = CP_RD;
            S_ALU:  cw = cp_with_alu(CP_ALU, dec.alu_op);
            S_WB:   cw = cp_with_alu(CP_WB, dec.alu_op);
            S_ST:   cw = CP_ST;
            default: cw = CP_IDLE;
        endcase
    end

    assign ctrl       = CTRL_W'(cw);
    assign stg1_state = (state == S_ACK);
    assign busy       = (state != S_IDLE);

endmodule
